// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forwarding-mux selects
// and the pipeline stage in which branches are resolved.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int BR_IN_D = 0;
  localparam int BR_IN_E = 1;

endpackage

// File: rtl/mdu_busy_ctr.sv
// Latency counter for the multiply/divide unit. A start while idle loads the
// op latency; the count then runs down to zero, with done flagged on the last
// busy cycle. Starts that arrive while busy are dropped.
module mdu_busy_ctr #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o,
  output logic done_o
);

  localparam int MAXLAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW     = $clog2(MAXLAT + 1);

  localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load on an accepted start, otherwise count down towards idle
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && (cnt_q == '0)) begin
      cnt_d = div_i ? DIV_LAT : MUL_LAT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a five-stage pipeline with a multi-cycle MDU: forwarding
// selects, load-use / branch / MDU stalls, flushes, and a stall statistic.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REGW       = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int BR_STAGE   = 0,
  parameter int CNTW       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            useRsD,
  input  logic            useRtD,
  input  logic            branchD,
  input  logic            jumpD,
  input  logic            pcsrcD,
  input  logic            takenE,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            mdu_startE,
  input  logic            mdu_divE,
  input  logic            mdu_useD,
  input  logic            stat_clr,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic            ForwardAD,
  output logic            ForwardBD,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            mdu_busy,
  output logic            mdu_done,
  output logic [CNTW-1:0] stall_count
);

  localparam bit BR_D = (BR_STAGE == BR_IN_D);
  localparam bit BR_E = (BR_STAGE == BR_IN_E);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  fwd_sel_e fwdAE;
  fwd_sel_e fwdBE;
  logic     lwStall;
  logic     brStall;
  logic     mduStall;
  logic     rawStall;
  logic     takenFlush;
  logic     stallInt;

  logic [CNTW-1:0] stallCnt_q;
  logic [CNTW-1:0] stallCnt_d;

  mdu_busy_ctr #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdu_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start_i(mdu_startE),
    .div_i  (mdu_divE),
    .busy_o (mdu_busy),
    .done_o (mdu_done)
  );

  // E-stage operand forwarding: the younger M result beats the W result
  always_comb begin
    fwdAE = FWD_RF;
    fwdBE = FWD_RF;
    if ((rsE != '0) && (rsE == writeregM) && regwriteM) begin
      fwdAE = FWD_M;
    end else if ((rsE != '0) && (rsE == writeregW) && regwriteW) begin
      fwdAE = FWD_W;
    end
    if ((rtE != '0) && (rtE == writeregM) && regwriteM) begin
      fwdBE = FWD_M;
    end else if ((rtE != '0) && (rtE == writeregW) && regwriteW) begin
      fwdBE = FWD_W;
    end
  end

  // D-stage branch-compare forwarding only exists when branches resolve in D
  always_comb begin
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (BR_D) begin
      ForwardAD = useRsD && (rsD != '0) && (rsD == writeregM) && regwriteM;
      ForwardBD = useRtD && (rtD != '0) && (rtD == writeregM) && regwriteM;
    end
  end

  // Stall sources: load-use, early branch operand not ready, MDU result pending
  always_comb begin
    lwStall = memtoregE && (rtE != '0) &&
              ((useRsD && (rtE == rsD)) || (useRtD && (rtE == rtD)));
    brStall = 1'b0;
    if (BR_D) begin
      brStall = branchD &&
                ((regwriteE && (writeregE != '0) &&
                  ((useRsD && (writeregE == rsD)) || (useRtD && (writeregE == rtD)))) ||
                 (memtoregM && (writeregM != '0) &&
                  ((useRsD && (writeregM == rsD)) || (useRtD && (writeregM == rtD)))));
    end
    mduStall = mdu_useD && (mdu_startE || (mdu_busy && !mdu_done));
  end

  // A taken E-stage branch squashes D and E, so it overrides any stall
  always_comb begin
    rawStall   = lwStall || brStall || mduStall;
    takenFlush = BR_E && takenE;
    stallInt   = rawStall && !takenFlush;
    FlushE     = stallInt || takenFlush;
    FlushD     = takenFlush || (!stallInt && (jumpD || (BR_D && pcsrcD)));
  end

  // Saturating stall statistic; clear takes priority over counting
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stat_clr) begin
      stallCnt_d = '0;
    end else if (stallInt && (stallCnt_q != CNT_MAX)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
  end

  // Stall statistic register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign StallD      = stallInt;
  assign StallF      = stallInt;
  assign ForwardAE   = fwdAE;
  assign ForwardBE   = fwdBE;
  assign stall_count = stallCnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (branch-in-D with wide counter,
// branch-in-E with 4-bit counter) share one stimulus and are compared every
// cycle against a rule-level model, plus hand-computed literal checks.
module tb_hazard_unit_mc;

  logic       clk;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       useRsD, useRtD, branchD, jumpD, pcsrcD, takenE;
  logic       memtoregE, memtoregM, regwriteE, regwriteM, regwriteW;
  logic       mdu_startE, mdu_divE, mdu_useD, stat_clr;

  logic        StallF0, StallD0, FlushD0, FlushE0, ForwardAD0, ForwardBD0;
  logic [1:0]  ForwardAE0, ForwardBE0;
  logic        mdu_busy0, mdu_done0;
  logic [31:0] stall_count0;

  logic        StallF1, StallD1, FlushD1, FlushE1, ForwardAD1, ForwardBD1;
  logic [1:0]  ForwardAE1, ForwardBE1;
  logic        mdu_busy1, mdu_done1;
  logic [3:0]  stall_count1;

  int checks   = 0;
  int failures = 0;

  // Model state: MDU cycles remaining and the two stall statistics
  int          remCycles;
  logic [31:0] statA;
  int          statB;

  hazard_unit_mc #(.REGW(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .BR_STAGE(0), .CNTW(32)) dut0 (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .useRsD(useRsD), .useRtD(useRtD), .branchD(branchD), .jumpD(jumpD),
    .pcsrcD(pcsrcD), .takenE(takenE), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .mdu_startE(mdu_startE), .mdu_divE(mdu_divE), .mdu_useD(mdu_useD), .stat_clr(stat_clr),
    .StallF(StallF0), .StallD(StallD0), .FlushD(FlushD0), .FlushE(FlushE0),
    .ForwardAD(ForwardAD0), .ForwardBD(ForwardBD0), .ForwardAE(ForwardAE0),
    .ForwardBE(ForwardBE0), .mdu_busy(mdu_busy0), .mdu_done(mdu_done0),
    .stall_count(stall_count0)
  );

  hazard_unit_mc #(.REGW(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .BR_STAGE(1), .CNTW(4)) dut1 (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .useRsD(useRsD), .useRtD(useRtD), .branchD(branchD), .jumpD(jumpD),
    .pcsrcD(pcsrcD), .takenE(takenE), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .mdu_startE(mdu_startE), .mdu_divE(mdu_divE), .mdu_useD(mdu_useD), .stat_clr(stat_clr),
    .StallF(StallF1), .StallD(StallD1), .FlushD(FlushD1), .FlushE(FlushE1),
    .ForwardAD(ForwardAD1), .ForwardBD(ForwardBD1), .ForwardAE(ForwardAE1),
    .ForwardBE(ForwardBE1), .mdu_busy(mdu_busy1), .mdu_done(mdu_done1),
    .stall_count(stall_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic usesReg(input logic [4:0] r);
    return (useRsD && r == rsD) || (useRtD && r == rtD);
  endfunction

  function automatic logic [1:0] fwdE(input logic [4:0] src);
    if (src != 0 && src == writeregM && regwriteM) return 2'b10;
    if (src != 0 && src == writeregW && regwriteW) return 2'b01;
    return 2'b00;
  endfunction

  // Expected stall/flush/D-forward outputs for a given branch-resolve stage
  function automatic void modelOut(input int br, output logic stall, output logic fD,
                                   output logic fE, output logic aD, output logic bD);
    logic lw, bs, md, tk, busy, done;
    busy  = remCycles > 0;
    done  = remCycles == 1;
    lw    = memtoregE && rtE != 0 && usesReg(rtE);
    bs    = (br == 0) && branchD &&
            ((regwriteE && writeregE != 0 && usesReg(writeregE)) ||
             (memtoregM && writeregM != 0 && usesReg(writeregM)));
    md    = mdu_useD && (mdu_startE || (busy && !done));
    tk    = (br == 1) && takenE;
    stall = (lw || bs || md) && !tk;
    fE    = stall || tk;
    fD    = tk || (!stall && (jumpD || (br == 0 && pcsrcD)));
    aD    = (br == 0) && useRsD && rsD != 0 && rsD == writeregM && regwriteM;
    bD    = (br == 0) && useRtD && rtD != 0 && rtD == writeregM && regwriteM;
  endfunction

  // Advance the model on each clock; reset clears it at once
  always @(posedge clk or negedge reset) begin
    logic s0, s1, d0, d1, d2, d3, d4, d5, d6, d7;
    if (!reset) begin
      remCycles <= 0;
      statA     <= 0;
      statB     <= 0;
    end else begin
      modelOut(0, s0, d0, d1, d2, d3);
      modelOut(1, s1, d4, d5, d6, d7);
      if (mdu_startE && remCycles == 0) remCycles <= mdu_divE ? 32 : 4;
      else if (remCycles > 0) remCycles <= remCycles - 1;
      if (stat_clr) begin
        statA <= 0;
        statB <= 0;
      end else begin
        if (s0 && statA != 32'hFFFF_FFFF) statA <= statA + 1;
        if (s1 && statB < 15) statB <= statB + 1;
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle
  always @(negedge clk) begin
    logic s, fD, fE, aD, bD;
    modelOut(0, s, fD, fE, aD, bD);
    checkOutput("m0_StallF", StallF0, s);
    checkOutput("m0_StallD", StallD0, s);
    checkOutput("m0_FlushD", FlushD0, fD);
    checkOutput("m0_FlushE", FlushE0, fE);
    checkOutput("m0_ForwardAD", ForwardAD0, aD);
    checkOutput("m0_ForwardBD", ForwardBD0, bD);
    checkOutput("m0_ForwardAE", ForwardAE0, fwdE(rsE));
    checkOutput("m0_ForwardBE", ForwardBE0, fwdE(rtE));
    checkOutput("m0_busy", mdu_busy0, remCycles > 0);
    checkOutput("m0_done", mdu_done0, remCycles == 1);
    checkOutput("m0_stall_count", stall_count0, statA);
    modelOut(1, s, fD, fE, aD, bD);
    checkOutput("m1_StallF", StallF1, s);
    checkOutput("m1_StallD", StallD1, s);
    checkOutput("m1_FlushD", FlushD1, fD);
    checkOutput("m1_FlushE", FlushE1, fE);
    checkOutput("m1_ForwardAD", ForwardAD1, aD);
    checkOutput("m1_ForwardBD", ForwardBD1, bD);
    checkOutput("m1_ForwardAE", ForwardAE1, fwdE(rsE));
    checkOutput("m1_ForwardBE", ForwardBE1, fwdE(rtE));
    checkOutput("m1_busy", mdu_busy1, remCycles > 0);
    checkOutput("m1_done", mdu_done1, remCycles == 1);
    checkOutput("m1_stall_count", {28'd0, stall_count1}, statB);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    useRsD = 0; useRtD = 0; branchD = 0; jumpD = 0; pcsrcD = 0; takenE = 0;
    memtoregE = 0; memtoregM = 0; regwriteE = 0; regwriteM = 0; regwriteW = 0;
    mdu_startE = 0; mdu_divE = 0; mdu_useD = 0; stat_clr = 0;
  endtask

  task automatic setLoadUse();
    memtoregE = 1; rtE = 5; rsD = 5; useRsD = 1;
  endtask

  initial begin
    int busyCycles, stallCycles, doneAt;
    reset = 1'b0;
    applyStimulus();
    tick();
    tick();
    checkOutput("rst_busy", mdu_busy0, 0);
    checkOutput("rst_count", stall_count0, 0);
    reset = 1'b1;
    tick();

    // Load-use with and without the rs read
    setLoadUse();
    #1;
    checkOutput("lu_StallF", StallF0, 1);
    checkOutput("lu_StallD", StallD0, 1);
    checkOutput("lu_FlushE", FlushE0, 1);
    tick();
    useRsD = 0;
    #1;
    checkOutput("lu_off_StallD", StallD0, 0);
    checkOutput("lu_off_FlushE", FlushE0, 0);
    tick();
    useRtD = 1; rtD = 5;
    tick();
    applyStimulus();

    // E-stage forward priority
    rsE = 3; writeregM = 3; writeregW = 3; regwriteM = 1; regwriteW = 1;
    #1;
    checkOutput("fwd_M", ForwardAE0, 2'b10);
    tick();
    regwriteM = 0;
    #1;
    checkOutput("fwd_W", ForwardAE0, 2'b01);
    tick();
    rsE = 0;
    #1;
    checkOutput("fwd_rf", ForwardAE0, 2'b00);
    tick();
    rtE = 7; writeregM = 7; regwriteM = 1;
    tick();
    applyStimulus();

    // Branch operand hazards (D-resolve instance only)
    branchD = 1; rsD = 4; useRsD = 1; regwriteE = 1; writeregE = 4;
    #1;
    checkOutput("br_E_stall0", StallD0, 1);
    checkOutput("br_E_stall1", StallD1, 0);
    tick();
    regwriteE = 0; memtoregM = 1; regwriteM = 1; writeregM = 4;
    tick();
    memtoregM = 0; useRtD = 1; rtD = 4;
    #1;
    checkOutput("fwd_AD", ForwardAD0, 1);
    checkOutput("fwd_BD", ForwardBD0, 1);
    tick();
    applyStimulus();
    jumpD = 1;
    #1;
    checkOutput("jump_FlushD", FlushD0, 1);
    tick();
    jumpD = 0; pcsrcD = 1; setLoadUse();
    #1;
    checkOutput("pcsrc_stalled_FlushD", FlushD0, 0);
    tick();
    applyStimulus();

    // Taken E-branch beats a load-use stall
    setLoadUse(); takenE = 1;
    #1;
    checkOutput("tk_StallD1", StallD1, 0);
    checkOutput("tk_FlushD1", FlushD1, 1);
    checkOutput("tk_FlushE1", FlushE1, 1);
    checkOutput("tk_StallD0", StallD0, 1);
    tick();
    applyStimulus();

    // Divide with a dependent D instruction throughout
    mdu_startE = 1; mdu_divE = 1; mdu_useD = 1;
    #1;
    checkOutput("div_start_stall", StallD0, 1);
    tick();
    mdu_startE = 0; mdu_divE = 0;
    busyCycles = 0; stallCycles = 0; doneAt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (mdu_busy0) busyCycles++;
      if (mdu_busy0 && StallD0) stallCycles++;
      if (mdu_done0) begin
        doneAt = i;
        checkOutput("div_done_stall", StallD0, 0);
      end
      tick();
    end
    checkOutput("div_busy_cycles", busyCycles, 32);
    checkOutput("div_done_at", doneAt, 32);
    checkOutput("div_stall_cycles", stallCycles, 31);
    applyStimulus();

    // Multiply, with further starts while busy being ignored
    mdu_startE = 1;
    tick();
    mdu_divE = 1;
    tick();
    tick();
    mdu_startE = 0; mdu_divE = 0;
    tick();
    checkOutput("mul_done", mdu_done0, 1);
    tick();
    checkOutput("mul_idle", mdu_busy0, 0);
    tick();

    // Stall statistic: clear wins over a stall, then count
    setLoadUse(); stat_clr = 1;
    tick();
    checkOutput("clr_count0", stall_count0, 0);
    checkOutput("clr_count1", {28'd0, stall_count1}, 0);
    stat_clr = 0;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("count10", stall_count0, 10);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("count20", stall_count0, 20);
    checkOutput("count_sat", {28'd0, stall_count1}, 15);
    applyStimulus();

    // Reset in the middle of a multiply
    mdu_startE = 1;
    tick();
    mdu_startE = 0;
    tick();
    tick();
    checkOutput("mid_mul_busy", mdu_busy0, 1);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_busy", mdu_busy0, 0);
    checkOutput("rst_mid_done", mdu_done0, 0);
    checkOutput("rst_mid_count0", stall_count0, 0);
    checkOutput("rst_mid_count1", {28'd0, stall_count1}, 0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("post_rst_busy", mdu_busy0, 0);
    tick();
    checkOutput("post_rst_busy2", mdu_busy0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
